// File: rtl/gb80_pkg.sv
// Shared GB80 definitions: ALU opcodes, 16-bit sequencer ops, flag bit
// positions and the 16-bit sequencer FSM states.
package gb80_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_ADD16 = 2'b00,
    SEQ_INC16 = 2'b01,
    SEQ_DEC16 = 2'b10,
    SEQ_ADDSP = 2'b11
  } seq16_op_e;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq16_state_e;

endpackage

// File: rtl/alu_seq16.sv
// 16-bit arithmetic sequencer: runs ADD HL,rr / INC rr / DEC rr / ADD SP,e8
// as two passes over the shared 8-bit ALU (low byte, then high byte with the
// carry chained) and merges the per-byte flags into a Game Boy F value.
module alu_seq16
  import gb80_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [1:0]                i_op,
  input  logic [2*DATA_WIDTH-1:0]   i_opa,
  input  logic [2*DATA_WIDTH-1:0]   i_opb,
  input  logic [7:0]                i_flags,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_result,
  output logic [7:0]                o_flags,
  output logic [DATA_WIDTH-1:0]     o_alu_a,
  output logic [DATA_WIDTH-1:0]     o_alu_b,
  output logic [OPCODE_WIDTH-1:0]   o_alu_ctrl,
  output logic                      o_alu_cin,
  input  logic [DATA_WIDTH-1:0]     i_alu_data,
  input  logic [7:0]                i_alu_flags
);

  seq16_state_e                state_q;
  seq16_op_e                   op_q;
  logic [2*DATA_WIDTH-1:0]     opa_q;
  logic [2*DATA_WIDTH-1:0]     opb_q;
  logic [3:0]                  fin_q;      // latched {Z,N,H,C} of incoming F
  logic [DATA_WIDTH-1:0]       res_lo_q;
  logic                        lo_h_q;
  logic                        lo_c_q;
  logic [2*DATA_WIDTH-1:0]     result_q;
  logic [7:0]                  flags_q;
  logic                        busy_q;
  logic                        done_q;

  alu_op_e                     alu_ctrl;
  logic [7:0]                  flags_d;

  // Only the Z/N/H/C nibble of the incoming F and the H/C bits of the ALU
  // flags carry information here.
  logic unused_bits;
  assign unused_bits = ^{i_flags[3:0], i_alu_flags[7:6], i_alu_flags[3:0]};

  // ALU drive: operand bytes, opcode and carry-in selected by phase and op.
  always_comb begin
    o_alu_a   = '0;
    o_alu_b   = '0;
    o_alu_cin = 1'b0;
    alu_ctrl  = ALU_ADD;
    unique case (state_q)
      ST_LO: begin
        o_alu_a = opa_q[DATA_WIDTH-1:0];
        unique case (op_q)
          SEQ_ADD16: o_alu_b = opb_q[DATA_WIDTH-1:0];
          SEQ_INC16: o_alu_b = DATA_WIDTH'(1);
          SEQ_DEC16: begin
            o_alu_b  = DATA_WIDTH'(1);
            alu_ctrl = ALU_SUB;
          end
          SEQ_ADDSP: o_alu_b = opb_q[DATA_WIDTH-1:0];
        endcase
      end
      ST_HI: begin
        o_alu_a   = opa_q[2*DATA_WIDTH-1:DATA_WIDTH];
        o_alu_cin = lo_c_q;
        alu_ctrl  = ALU_ADC;
        unique case (op_q)
          SEQ_ADD16: o_alu_b = opb_q[2*DATA_WIDTH-1:DATA_WIDTH];
          SEQ_INC16: o_alu_b = '0;
          SEQ_DEC16: begin
            o_alu_b  = '0;
            alu_ctrl = ALU_SBC;
          end
          SEQ_ADDSP: o_alu_b = {DATA_WIDTH{opb_q[DATA_WIDTH-1]}};
        endcase
      end
      default: ;
    endcase
  end

  assign o_alu_ctrl = OPCODE_WIDTH'(alu_ctrl);

  // Flag merge, evaluated during HI so F lands together with the result.
  always_comb begin
    flags_d = '0;
    unique case (op_q)
      SEQ_ADD16: flags_d = {fin_q[3], 1'b0, i_alu_flags[FLAG_H], i_alu_flags[FLAG_C], 4'b0000};
      SEQ_INC16,
      SEQ_DEC16: flags_d = {fin_q, 4'b0000};
      SEQ_ADDSP: flags_d = {2'b00, lo_h_q, lo_c_q, 4'b0000};
    endcase
  end

  // Sequencer FSM: latch request, capture low byte, capture high byte, pulse done.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= SEQ_ADD16;
      opa_q    <= '0;
      opb_q    <= '0;
      fin_q    <= '0;
      res_lo_q <= '0;
      lo_h_q   <= 1'b0;
      lo_c_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            op_q    <= seq16_op_e'(i_op);
            opa_q   <= i_opa;
            opb_q   <= i_opb;
            fin_q   <= i_flags[7:4];
            busy_q  <= 1'b1;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          res_lo_q <= i_alu_data;
          lo_h_q   <= i_alu_flags[FLAG_H];
          lo_c_q   <= i_alu_flags[FLAG_C];
          state_q  <= ST_HI;
        end
        ST_HI: begin
          result_q <= {i_alu_data, res_lo_q};
          flags_q  <= flags_d;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: behavioural 8-bit ALU attached to the
// ALU ports, and a 16-bit reference model for results and merged flags.
module tb_alu_seq16;
  import gb80_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic [7:0]  fin = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flags;
  logic [7:0]  alu_a, alu_b, alu_data, alu_flags;
  logic [2:0]  alu_ctrl;
  logic        alu_cin;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_res = '0;
  logic [7:0]  last_flags = '0;

  always #5 clk = ~clk;

  alu_seq16 #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_opa(opa), .i_opb(opb), .i_flags(fin),
    .o_busy(busy), .o_done(done), .o_result(result), .o_flags(flags),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl), .o_alu_cin(alu_cin),
    .i_alu_data(alu_data), .i_alu_flags(alu_flags)
  );

  // Behavioural GB80 8-bit ALU: returns {F, data}.
  function automatic logic [15:0] alu_fn(input logic [2:0] ctrl, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    int unsigned ia, ib, ic, s;
    logic [7:0] r;
    logic n, h, c;
    ia = a; ib = b; ic = 0; n = 1'b0; h = 1'b0; c = 1'b0;
    case (ctrl)
      3'd0, 3'd1: begin
        if (ctrl == 3'd1) ic = cin;
        s = ia + ib + ic;
        r = s[7:0];
        h = ((ia % 16) + (ib % 16) + ic) > 15;
        c = s > 255;
      end
      3'd2, 3'd3, 3'd7: begin
        if (ctrl == 3'd3) ic = cin;
        s = ia + 256 - ib - ic;
        r = s[7:0];
        n = 1'b1;
        h = (ia % 16) < ((ib % 16) + ic);
        c = ia < (ib + ic);
        if (ctrl == 3'd7) r = a;
      end
      3'd4: begin r = a & b; h = 1'b1; end
      3'd5: r = a ^ b;
      default: r = a | b;
    endcase
    return {(r == 8'h00), n, h, c, 4'b0000, r};
  endfunction

  assign {alu_flags, alu_data} = alu_fn(alu_ctrl, alu_a, alu_b, alu_cin);

  // 16-bit reference: returns {result, F}.
  function automatic logic [23:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic [7:0] f);
    int unsigned ia, ib, e, s;
    logic h, c;
    logic [15:0] r;
    logic [7:0] nf;
    ia = a; ib = b;
    case (o)
      2'b00: begin
        s = ia + ib;
        r = s[15:0];
        h = ((ia % 4096) + (ib % 4096)) > 4095;
        c = s > 65535;
        nf = {f[7], 1'b0, h, c, 4'b0000};
      end
      2'b01: begin s = ia + 1; r = s[15:0]; nf = {f[7:4], 4'b0000}; end
      2'b10: begin s = ia + 65535; r = s[15:0]; nf = {f[7:4], 4'b0000}; end
      default: begin
        e = ib % 256;
        s = (e >= 128) ? ia + 65536 + e - 256 : ia + e;
        r = s[15:0];
        h = ((ia % 16) + (e % 16)) > 15;
        c = ((ia % 256) + e) > 255;
        nf = {2'b00, h, c, 4'b0000};
      end
    endcase
    return {r, nf};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f);
    logic [23:0] exp;
    logic [2:0]  lo_ctrl, hi_ctrl;
    exp = ref_model(o, a, b, f);
    lo_ctrl = (o == 2'b10) ? 3'd2 : 3'd0;
    hi_ctrl = (o == 2'b10) ? 3'd3 : 3'd1;
    op = o; opa = a; opb = b; fin = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); fin = 8'($urandom);
    // LO
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL lo_status busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    checks++;
    if (alu_a !== a[7:0] || alu_ctrl !== lo_ctrl || alu_cin !== 1'b0) begin
      errors++; $display("FAIL lo_alu a=%h ctrl=%0d cin=%b exp a=%h ctrl=%0d cin=0",
                         alu_a, alu_ctrl, alu_cin, a[7:0], lo_ctrl);
    end
    checks++;
    if (result !== last_res) begin
      errors++; $display("FAIL lo_hold result=%h exp %h", result, last_res);
    end
    @(posedge clk); #1;
    // HI
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || alu_a !== a[15:8] || alu_ctrl !== hi_ctrl) begin
      errors++; $display("FAIL hi_phase busy=%b done=%b a=%h ctrl=%0d exp 1 0 %h %0d",
                         busy, done, alu_a, alu_ctrl, a[15:8], hi_ctrl);
    end
    @(posedge clk); #1;
    // DONE
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL done_pulse done=%b busy=%b exp 1 1", done, busy);
    end
    checks++;
    if (result !== exp[23:8] || flags !== exp[7:0]) begin
      errors++; $display("FAIL result op=%0d a=%h b=%h f=%h got %h/%h exp %h/%h",
                         o, a, b, f, result, flags, exp[23:8], exp[7:0]);
    end
    last_res = exp[23:8]; last_flags = exp[7:0];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== last_res || flags !== last_flags) begin
      errors++; $display("FAIL idle_after done=%b busy=%b res=%h fl=%h exp 0 0 %h %h",
                         done, busy, result, flags, last_res, last_flags);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0 || flags !== 8'h0) begin
      errors++; $display("FAIL reset_out busy=%b done=%b res=%h fl=%h exp all 0",
                         busy, done, result, flags);
    end
    checks++;
    if (alu_a !== 8'h0 || alu_b !== 8'h0 || alu_ctrl !== 3'd0 || alu_cin !== 1'b0) begin
      errors++; $display("FAIL reset_alu a=%h b=%h ctrl=%0d cin=%b exp all 0",
                         alu_a, alu_b, alu_ctrl, alu_cin);
    end
    rst_n = 1'b1;
    last_res = '0; last_flags = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h80);
    run_op(2'b00, 16'hFFFF, 16'h0001, 8'h00);
    run_op(2'b01, 16'hFFFF, 16'h1234, 8'h50);
    run_op(2'b10, 16'h0000, 16'hABCD, 8'h50);
    run_op(2'b11, 16'hFFF8, 16'h0008, 8'hF0);
    run_op(2'b11, 16'h0000, 16'h00FF, 8'hF0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
  endtask

  // Start held high with fresh inputs every cycle: only edges 0,4,8 accept.
  task automatic test_back_to_back();
    logic [23:0] q[$];
    logic [23:0] exp;
    int ndone = 0;
    for (int c = 0; c < 12; c++) begin
      start = 1'b1;
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); fin = 8'($urandom);
      if (c % 4 == 0) q.push_back(ref_model(op, opa, opb, fin));
      @(posedge clk); #1;
      checks++;
      if (done !== (c % 4 == 2)) begin
        errors++; $display("FAIL b2b_done cycle=%0d done=%b exp %b", c, done, (c % 4 == 2));
      end
      if (done === 1'b1) begin
        ndone++;
        exp = (q.size() > 0) ? q.pop_front() : 24'hxxxxxx;
        checks++;
        if (result !== exp[23:8] || flags !== exp[7:0]) begin
          errors++; $display("FAIL b2b_result cycle=%0d got %h/%h exp %h/%h",
                             c, result, flags, exp[23:8], exp[7:0]);
        end
        last_res = exp[23:8]; last_flags = exp[7:0];
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++; $display("FAIL b2b_count dones=%0d exp 3", ndone);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    op = 2'b00; opa = 16'h1234; opb = 16'h4321; fin = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0 || flags !== 8'h0) begin
      errors++; $display("FAIL rst_mid busy=%b done=%b res=%h fl=%h exp all 0",
                         busy, done, result, flags);
    end
    last_res = '0; last_flags = '0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nodone done=%b busy=%b exp 0 0", done, busy);
    end
    run_op(2'b00, 16'h8000, 16'h8000, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
# alu_seq16

Multi-cycle sequencer that runs GB80's 16-bit arithmetic on the shared 8-bit `alu`. It supports ADD HL,rr, INC rr, DEC rr and ADD SP,e8 by driving the ALU twice: low byte first, then high byte with the carry chained. It then merges the per-byte flags into a Game Boy F value. The block sits between instruction decode and the `alu` and owns the ALU ports while busy.

## Interface
- `DATA_WIDTH`, 8, ALU byte width; the result is 2×`DATA_WIDTH`.
- `OPCODE_WIDTH`, 3, ALU control width.
- `i_clk` in 1: single clock; all logic on the rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: request; accepted only when `o_busy`=0.
- `i_op` in 2: 00 ADD16, 01 INC16, 10 DEC16, 11 ADDSP.
- `i_opa` in 16: first operand (HL, rr or SP).
- `i_opb` in 16: second operand. ADD16 uses all 16 bits; ADDSP uses `i_opb[7:0]` as signed e8; ignored otherwise.
- `i_flags` in 8: current F, latched at start.
- `o_busy` out 1: high in LO, HI and DONE.
- `o_done` out 1: one-cycle pulse; result and flags valid.
- `o_result` out 16: result; holds until the next accepted start.
- `o_flags` out 8: new F as {Z,N,H,C,0000}; holds like `o_result`.
- `o_alu_a` out 8: ALU operand A.
- `o_alu_b` out 8: ALU operand B.
- `o_alu_ctrl` out 3: ALU opcode.
- `o_alu_cin` out 1: ALU carry-in, feeds ALU `i_flags[4]`.
- `i_alu_data` in 8: ALU result (combinational, same cycle).
- `i_alu_flags` in 8: ALU flags (same cycle).

## Operation
- FSM: IDLE → LO → HI → DONE → IDLE. There are no other transitions except reset.
- **IDLE**
  - When `i_start`=1, latch `i_op`, `i_opa`, `i_opb` and `i_flags`, then go to LO.
  - ALU outputs are 0 and `o_alu_ctrl`=ADD.
- **LO**
  - `o_alu_a` = opa[7:0] and `o_alu_cin`=0.
  - ADD16: b = opb[7:0], ctrl ADD.
  - INC16: b = 0x01, ctrl ADD.
  - DEC16: b = 0x01, ctrl SUB.
  - ADDSP: b = e8, ctrl ADD.
  - At the clock edge, register `res_lo`, `lo_h` = alu H (bit 5) and `lo_c` = alu C (bit 4).
- **HI**
  - `o_alu_a` = opa[15:8] and `o_alu_cin` = `lo_c`.
  - ADD16: b = opb[15:8], ctrl ADC.
  - INC16: b = 0x00, ctrl ADC.
  - DEC16: b = 0x00, ctrl SBC (carry = borrow).
  - ADDSP: b = {8{e8[7]}}, ctrl ADC.
  - At the clock edge, register `res_hi`, `hi_h` and `hi_c`.
- **DONE**
  - `o_done`=1 and `o_result` = {res_hi,res_lo}.
  - ADD16: F = {Zlatched, 0, hi_h, hi_c, 0000}. H is carry from bit 11; C is carry from bit 15.
  - INC16/DEC16: F = latched F unchanged.
  - ADDSP: F = {0, 0, lo_h, lo_c, 0000}.
  - The low nibble of `o_flags` is always 0.
- `i_start` while busy (LO, HI or DONE) is ignored and not queued.
- Wrap-around is modulo 2^16: 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF.
- **Reset** (`i_rst_n`=0 at an edge): FSM goes to IDLE and all outputs become 0, including `o_result`, `o_flags` and `o_busy`. `o_alu_ctrl` = ADD.
- **Reset mid-operation** abandons the op: no `o_done` is produced and `o_result` is cleared.

## Timing
- `i_start` sampled at edge k:
  - LO occupies cycle k→k+1.
  - HI occupies cycle k+1→k+2.
  - `o_done` is high for exactly cycle k+2→k+3.
  - `o_busy` is high over the same three cycles.
- New `o_result`/`o_flags` values appear together with `o_done` and are stable until the edge after the next accepted start.
- A start asserted in the cycle after `o_done` is accepted, so throughput is one op per 4 cycles.
- ALU paths are combinational within a cycle; the block registers only at state boundaries.

## Structure
- Shared package `gb80_pkg` holds:
  - ALU opcodes: ADD=0, ADC=1, SUB=2, SBC=3, AND=4, XOR=5, OR=6, CP=7.
  - `seq16_op` encodings.
  - Flag bit indices: Z=7, N=6, H=5, C=4.
  - FSM state encoding.
- Single module, no sub-module. Flag merge is a small combinational block inside.

## Test plan
- ADD16, opa 0x0FFF, opb 0x0001, F 0x80 → result 0x1000, flags 0xA0; `o_done` at edge k+2→k+3.
- ADD16, 0xFFFF + 0x0001, F 0x00 → result 0x0000, flags 0x30.
- INC16 0xFFFF with F 0x50 → 0x0000, flags 0x50. DEC16 0x0000 with F 0x50 → 0xFFFF, flags 0x50.
- ADDSP, SP 0xFFF8, e8 0x08 → 0x0000, flags 0x30. ADDSP, SP 0x0000, e8 0xFF → 0xFFFF, flags 0x00.
- `i_start` held high continuously → ops accepted every 4 cycles; starts during LO/HI/DONE are ignored; one `o_done` per accepted op.
- Assert `i_rst_n`=0 during HI → next cycle IDLE, `o_busy`=0, no `o_done`, `o_result`=0; a fresh ADD16 after release completes normally.
